jt49_noise_chk: RTL and testbench

Receive-side checker for the JT49 17-bit noise polynomial. It takes the 1-bit noise stream and a per-bit strobe, self-synchronises a local copy of the LFSR, and predicts every following bit. It then reports lock status and counts mismatches. It sits on the consumer side of the noise generator and serves as a built-in self-test and a sync monitor for captured or replayed PSG noise.

---
 rtl/jt49_noise_chk.sv | 110 +++++++++++
 tb/tb_jt49_noise_chk.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/jt49_noise_chk.sv
// jt49_noise_chk: self-synchronising checker for the JT49 17-bit noise LFSR stream.
// Hunts for 17 bits, verifies predictions, then flywheels in lock while counting errors.
module jt49_noise_chk #(
    parameter logic INV      = 1'b1,
    parameter int   LOCK_CNT = 34,
    parameter int   LOSS_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        bit_vld,
    input  logic        noise_in,
    input  logic        clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCK = 2'd2} st_t;
    st_t         st_q, st_d;
    logic [16:0] h_q, h_d;
    logic [4:0]  fill_q, fill_d;
    logic [7:0]  good_q, good_d;
    logic [3:0]  bad_q, bad_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        acc, b, p, mis, err;

    assign acc = cen & bit_vld;
    assign b   = noise_in ^ INV;
    // Same recurrence as the generator, including its zero-lockup escape
    assign p   = h_q[0] ^ h_q[3] ^ (h_q == 17'd0);
    assign mis = b ^ p;
    assign err = acc && st_q == LOCK && mis;

    always_comb begin
        st_d   = st_q;
        h_d    = h_q;
        fill_d = fill_q;
        good_d = good_q;
        bad_d  = bad_q;
        if (acc) begin
            case (st_q)
                HUNT: begin
                    h_d    = {b, h_q[16:1]};
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd16) begin
                        st_d   = VERIFY;
                        good_d = '0;
                    end
                end
                VERIFY: begin
                    h_d = {b, h_q[16:1]};
                    if (mis) begin
                        st_d   = HUNT;
                        fill_d = 5'd1;
                    end else begin
                        good_d = good_q + 8'd1;
                        if (good_d == 8'(LOCK_CNT)) begin
                            st_d  = LOCK;
                            bad_d = '0;
                        end
                    end
                end
                LOCK: begin
                    // Flywheel: keep the local LFSR running on its own prediction
                    h_d   = {p, h_q[16:1]};
                    bad_d = mis ? bad_q + 4'd1 : 4'd0;
                    if (bad_d == 4'(LOSS_CNT)) begin
                        st_d   = HUNT;
                        fill_d = '0;
                    end
                end
                default: st_d = HUNT;
            endcase
        end
        locked_d    = st_d == LOCK;
        err_pulse_d = cen ? err : err_pulse_q;
        err_cnt_d   = err_cnt_q + 16'(err && err_cnt_q != 16'hFFFF);
        if (cen && clr) err_cnt_d = {15'd0, err};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= HUNT;
            h_q         <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            st_q        <= st_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign state     = st_q;
endmodule

// File: tb/tb_jt49_noise_chk.sv
// tb_jt49_noise_chk: table-driven bench for jt49_noise_chk fed by a generator LFSR model.
// A second instance with LOSS_CNT=15 covers counter saturation.
module tb_jt49_noise_chk;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0, bit_vld = 1'b0, noise_in = 1'b0, clr = 1'b0;
    logic        cen2 = 1'b0, bit_vld2 = 1'b0, noise_in2 = 1'b0, clr2 = 1'b0;
    logic        locked, err_pulse, locked2, err_pulse2;
    logic [15:0] err_cnt, err_cnt2;
    logic [1:0]  state, state2;
    logic [16:0] g1 = '0, g2 = '0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    jt49_noise_chk dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .bit_vld(bit_vld), .noise_in(noise_in),
        .clr(clr), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state)
    );

    jt49_noise_chk #(.LOSS_CNT(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .cen(cen2), .bit_vld(bit_vld2), .noise_in(noise_in2),
        .clr(clr2), .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .state(state2)
    );

    typedef struct {
        string       name;
        int          rep;
        logic        c, v, f, cl;
        logic        el, ep;
        logic [15:0] ec;
        logic [1:0]  es;
    } vec_t;

    function automatic logic [16:0] lfsr(input logic [16:0] x);
        return {x[0] ^ x[3] ^ (x == 17'd0), x[16:1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; f inverts the bit relative to the generator stream
    task automatic drive(input bit d2, input logic c, input logic v, input logic f, input logic cl);
        if (!d2) begin
            cen = c; bit_vld = v; clr = cl;
            if (c & v) g1 = lfsr(g1);
            noise_in = ~g1[0] ^ f;
        end else begin
            cen2 = c; bit_vld2 = v; clr2 = cl;
            if (c & v) g2 = lfsr(g2);
            noise_in2 = ~g2[0] ^ f;
        end
        @(posedge clk); #1;
    endtask

    task automatic bits(input bit d2, input int n, input logic f);
        for (int i = 0; i < n; i++) drive(d2, 1'b1, 1'b1, f, 1'b0);
    endtask

    task automatic chk_main(input string name, input logic el, input logic ep,
                            input logic [15:0] ec, input logic [1:0] es);
        chk({name, ".locked"}, locked, el);
        chk({name, ".err_pulse"}, err_pulse, ep);
        chk({name, ".err_cnt"}, err_cnt, ec);
        chk({name, ".state"}, state, es);
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{"hunt_verify",    50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'd1};
        tbl[1]  = '{"lock_bit51",      1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd2};
        tbl[2]  = '{"clean_1000",    949, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd2};
        tbl[3]  = '{"single_err",      1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 2'd2};
        tbl[4]  = '{"pulse_clear",     1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 2'd2};
        tbl[5]  = '{"flywheel_100",   99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 2'd2};
        tbl[6]  = '{"err_pre_gate",    1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 2'd2};
        tbl[7]  = '{"cen_gate",        6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 2'd2};
        tbl[8]  = '{"after_gate",      1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 2'd2};
        tbl[9]  = '{"loss_2bad",       2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4, 2'd2};
        tbl[10] = '{"loss_3rd",        1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 2'd0};
        tbl[11] = '{"relock_50",      50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 2'd1};
        tbl[12] = '{"relock_51",       1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, 2'd2};
        tbl[13] = '{"clr_alone",       1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 2'd2};
        tbl[14] = '{"clr_and_err",     1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 2'd2};
        tbl[15] = '{"err_again",       1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 2'd2};
        tbl[16] = '{"recover",         1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 2'd2};

        repeat (2) @(posedge clk);
        #1;
        chk_main("reset", 1'b0, 1'b0, 16'd0, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < tbl[i].rep; r++)
                drive(1'b0, tbl[i].c, tbl[i].v, tbl[i].f, tbl[i].cl);
            chk_main(tbl[i].name, tbl[i].el, tbl[i].ep, tbl[i].ec, tbl[i].es);
        end

        // Asynchronous reset while locked, observed before any clock edge
        cen = 1'b0; bit_vld = 1'b0;
        #1 rst_n = 1'b0;
        #2 chk_main("async_rst", 1'b0, 1'b0, 16'd0, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        g1 = '0;

        // Bit 20 aborts VERIFY; the corrupted bit sits in the refilled history and
        // aborts the next VERIFY at bit 37, so lock first comes at 37 + 16 + 34 = 87
        bits(1'b0, 19, 1'b0);
        chk("abort.pre_state", state, 2'd1);
        bits(1'b0, 1, 1'b1);
        chk_main("abort.bit20", 1'b0, 1'b0, 16'd0, 2'd0);
        bits(1'b0, 16, 1'b0);
        chk("abort.bit36_state", state, 2'd1);
        bits(1'b0, 1, 1'b0);
        chk("abort.bit37_state", state, 2'd0);
        bits(1'b0, 49, 1'b0);
        chk_main("abort.bit86", 1'b0, 1'b0, 16'd0, 2'd1);
        bits(1'b0, 1, 1'b0);
        chk_main("abort.bit87", 1'b1, 1'b0, 16'd0, 2'd2);
        cen = 1'b0; bit_vld = 1'b0;

        // Saturation on the LOSS_CNT=15 instance: groups of 14 errors and 1 good bit
        bits(1'b1, 51, 1'b0);
        chk("sat.locked", locked2, 1'b1);
        for (int gi = 0; gi < 4681; gi++) begin
            bits(1'b1, 14, 1'b1);
            bits(1'b1, 1, 1'b0);
        end
        chk("sat.fffe", err_cnt2, 16'hFFFE);
        chk("sat.still_locked", locked2, 1'b1);
        bits(1'b1, 1, 1'b1);
        chk("sat.ffff", err_cnt2, 16'hFFFF);
        bits(1'b1, 1, 1'b1);
        chk("sat.hold", err_cnt2, 16'hFFFF);
        chk("sat.pulse", err_pulse2, 1'b1);
        bits(1'b1, 1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("sat.clr_err", err_cnt2, 16'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sat.clr_only", err_cnt2, 16'd0);
        chk("sat.locked_end", locked2, 1'b1);
        chk("sat.state_end", state2, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
